// File: rtl/uart_reg_bridge_if.sv
// Purpose: UART byte stream and register bus signals between the bridge and its environment.
// Latency: none; this is a wiring bundle only.
// Backpressure: rx_ready/rx_ack level handshake on receive, tx_busy holds off transmit.
interface uart_reg_bridge_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic [7:0] err_count;

    // Bridge side: consumes UART bytes, drives the register bus and reply path.
    modport master (
        input  rx_data, rx_ready, tx_busy, reg_rdata,
        output rx_ack, tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_re, err_count
    );

    // Environment side: UART and register file.
    modport slave (
        output rx_data, rx_ready, tx_busy, reg_rdata,
        input  rx_ack, tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_re, err_count
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// Purpose: decodes W/R byte packets from a UART into register bus strobes and sends one reply byte.
// Latency: strobe 1 cycle after the last packet byte is captured; reply request 1-2 cycles after that.
// Backpressure: bytes stay pending (no rx_ack) while a command executes; reply waits for tx_busy low.
module uart_reg_bridge #(
    parameter int         TIMEOUT_CLKS = 100000,
    parameter logic [7:0] CMD_WR       = 8'h57,
    parameter logic [7:0] CMD_RD       = 8'h52
) (
    input  logic              clk,
    input  logic              rst,
    uart_reg_bridge_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    localparam logic [7:0] RPL_OK  = 8'h4B;
    localparam logic [7:0] RPL_BAD = 8'h3F;

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] GET_ADDR  = 4'd1;
    localparam logic [3:0] GET_DATA  = 4'd2;
    localparam logic [3:0] BUS_WR    = 4'd3;
    localparam logic [3:0] BUS_RD    = 4'd4;
    localparam logic [3:0] RD_CAP    = 4'd5;
    localparam logic [3:0] SEND      = 4'd6;
    localparam logic [3:0] WAIT_BUSY = 4'd7;
    localparam logic [3:0] WAIT_DONE = 4'd8;

    logic [3:0]       state_q,     state_d;
    logic             is_wr_q,     is_wr_d;
    logic             rx_ack_q,    rx_ack_d;
    logic [7:0]       tx_data_q,   tx_data_d;
    logic             tx_start_q,  tx_start_d;
    logic [7:0]       reg_addr_q,  reg_addr_d;
    logic [7:0]       reg_wdata_q, reg_wdata_d;
    logic [7:0]       err_q,       err_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic in_packet;
    logic accepting;
    logic capture;
    logic timeout;
    logic err_inc;

    // Byte capture and inter-byte timeout detection.
    always_comb begin
        in_packet = (state_q == GET_ADDR) || (state_q == GET_DATA);
        accepting = (state_q == IDLE) || in_packet;
        capture   = accepting && bus.rx_ready && !rx_ack_q;
        timeout   = in_packet && !capture && (cnt_q == CNT_LAST);
        // Once acknowledged, hold rx_ack until the UART withdraws rx_ready.
        rx_ack_d  = rx_ack_q ? bus.rx_ready : capture;
        // Counter only runs between bytes of a packet; everything else clears it.
        if (in_packet && !capture && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    // Packet sequencing, bus strobes and reply selection.
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        err_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    if (bus.rx_data == CMD_WR) begin
                        is_wr_d = 1'b1;
                        state_d = GET_ADDR;
                    end else if (bus.rx_data == CMD_RD) begin
                        is_wr_d = 1'b0;
                        state_d = GET_ADDR;
                    end else begin
                        tx_data_d = RPL_BAD;
                        err_inc   = 1'b1;
                        state_d   = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (capture) begin
                    reg_addr_d = bus.rx_data;
                    state_d    = is_wr_q ? GET_DATA : BUS_RD;
                end else if (timeout) begin
                    err_inc = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                if (capture) begin
                    reg_wdata_d = bus.rx_data;
                    state_d     = BUS_WR;
                end else if (timeout) begin
                    err_inc = 1'b1;
                    state_d = IDLE;
                end
            end
            BUS_WR: begin
                tx_data_d = RPL_OK;
                state_d   = SEND;
            end
            BUS_RD: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                // Read data arrives one cycle after the reg_re strobe.
                tx_data_d = bus.reg_rdata;
                state_d   = SEND;
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Error counter sticks at all-ones instead of wrapping.
        if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers, cleared asynchronously so a reset drops any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            rx_ack_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            err_q       <= 8'h00;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            rx_ack_q    <= rx_ack_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Strobes decode straight from the state so reg_rdata lines up with RD_CAP.
    assign bus.reg_we    = (state_q == BUS_WR);
    assign bus.reg_re    = (state_q == BUS_RD);
    assign bus.rx_ack    = rx_ack_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.err_count = err_q;

endmodule
